i2c_target_regfile: RTL and testbench
=====================================

# i2c_target_regfile

I2C target (responder) with an internal byte-wide register file, clocked by the 50 MHz system clock. It is the far end of the I2C write path from the HDMI init sequencer: it answers at the same 8-bit device address (0x72) and ACKs the device byte, the register byte and the data bytes. Each write it accepts is stored and also reported on a strobe port. It serves as the on-chip/bench partner for the I2C controller and as a reusable register target for other blocks.

## Interface
- DEV_ADDR, 8'h72: 8-bit write-form device address; bit 0 ignored in compare.
- REG_AW, 4: register file address width; depth 2**REG_AW, 8-bit entries.
- clk_ref  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- i2c_scl  in  1  bus SCL, asynchronous.
- i2c_sda_in  in  1  bus SDA sampled level, asynchronous.
- i2c_sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- busy  out  1  high from START until STOP or NACK-release.
- wr_valid  out  1  one-cycle pulse per accepted data byte.
- wr_addr  out  REG_AW  register index of the byte being written.
- wr_data  out  8  data byte being written.
- rd_addr  in  REG_AW  fabric-side read index.
- rd_data  out  8  register contents at rd_addr, 1-cycle registered latency.

## Operation
- SCL/SDA pass through 2-flop synchronizers, then 1-flop edge detect. Events: scl_rise, scl_fall, START (SDA falls while SCL high), STOP (SDA rises while SCL high).
- States: IDLE, DEV, DEV_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- START from any state -> DEV, bit counter = 0. Repeated START is legal. STOP from any state -> IDLE, i2c_sda_oe = 0.
- Bits are shifted in MSB-first on scl_rise. SDA output changes only on scl_fall.
- DEV: after 8 bits, if byte[7:1] == DEV_ADDR[7:1], go to DEV_ACK and assert i2c_sda_oe on the next scl_fall. On mismatch, return to IDLE with SDA released and ignore the bus until the next START.
- ACK slot: i2c_sda_oe is held through one SCL high phase and released on the following scl_fall.
- After DEV_ACK: R/W=0 -> REG. R/W=1 -> RDATA (see Configuration).
- REG: 8 bits; the low REG_AW bits load the pointer and the upper bits are ignored. Always ACK.
- WDATA: after 8 bits, write the register at the pointer, pulse wr_valid for one cycle with wr_addr/wr_data, ACK, increment the pointer modulo depth (wraps 2**REG_AW-1 -> 0), then go back to WDATA.
- RDATA: drive the register at the pointer MSB-first (oe = ~bit) on successive scl_fall. In RDATA_ACK, sample the controller's ACK on scl_rise: ACK -> increment pointer, next byte; NACK -> release SDA and wait for STOP or START.
- If the fabric rd_addr and a bus write hit the same index in the same cycle, rd_data returns the old value.
- Reset: state IDLE, pointer 0, all registers 0, i2c_sda_oe 0, busy 0, wr_valid 0, wr_addr 0, wr_data 0, rd_data 0. Reset mid-transfer abandons the byte and releases SDA in the next cycle.

## Timing
- Event detection latency is 3 clk_ref cycles after a bus edge.
- i2c_sda_oe changes within 4 cycles of the SCL falling edge.
- wr_valid is asserted 4 cycles after the 8th data-bit SCL rising edge.
- Required bus timing: SCL high and low phases ≥ 8 clk_ref cycles each; SDA setup/hold around SCL edges ≥ 4 cycles.
- rd_data is registered: rd_addr presented in cycle N gives data in cycle N+1.

## Configuration
- I2C_TARGET_READ_EN defined: RDATA/RDATA_ACK are present and read transactions are served with pointer auto-increment.
- I2C_TARGET_READ_EN not defined: RDATA/RDATA_ACK are absent. A device byte with R/W=1 is NACKed (SDA released) and the block waits for STOP or START. Writes are unaffected.

## Structure
- Shared package holds the state encoding constants (one-hot, matching the codebase's state style), I2C_ACK/I2C_NACK levels, and the default device address 8'h72.
- One sub-module: i2c_bus_sync, which contains the 2-flop synchronizers for SCL and SDA plus edge, START and STOP detection. Outputs are scl_rise, scl_fall, start_det, stop_det and sda_s.
- The register file is inferred inside the top module.

## Test plan
- Write 0x72, 0xA5, 0x33, STOP -> ACK on all three bytes; wr_valid pulses once with wr_addr=0x5, wr_data=0x33; register 5 reads back 0x33 via rd_addr.
- Device byte 0x70 -> no ACK (SDA stays released), no wr_valid, busy drops; the next transfer to 0x72 succeeds.
- Burst 0x72, 0x0F, 0x11, 0x22 -> register 15 = 0x11, register 0 = 0x22 (wrap); two wr_valid pulses.
- With READ_EN: 0x72, 0x05, repeated START, 0x73, controller ACK then NACK -> SDA carries 0x33 then the contents of register 6; SDA released after the NACK. Without READ_EN: the 0x73 byte is NACKed.
- reset asserted mid data byte -> i2c_sda_oe = 0 and state IDLE next cycle; registers cleared; a following complete write works.
- STOP between the register byte and data -> no write occurs; the pointer is retained for a following read.

Source files
------------

// File: rtl/i2c_target_regfile_pkg.sv
// Shared constants for the I2C register-file target.
// One-hot state encoding, bus levels and the default device address.
package i2c_target_regfile_pkg;

  localparam logic [7:0] I2C_DEV_ADDR = 8'h72;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int I_IDLE      = 0;
  localparam int I_DEV       = 1;
  localparam int I_DEV_ACK   = 2;
  localparam int I_REG       = 3;
  localparam int I_REG_ACK   = 4;
  localparam int I_WDATA     = 5;
  localparam int I_WDATA_ACK = 6;
  localparam int I_RDATA     = 7;
  localparam int I_RDATA_ACK = 8;

  typedef logic [8:0] state_t;

  localparam state_t S_IDLE      = 9'b000000001;
  localparam state_t S_DEV       = 9'b000000010;
  localparam state_t S_DEV_ACK   = 9'b000000100;
  localparam state_t S_REG       = 9'b000001000;
  localparam state_t S_REG_ACK   = 9'b000010000;
  localparam state_t S_WDATA     = 9'b000100000;
  localparam state_t S_WDATA_ACK = 9'b001000000;
  localparam state_t S_RDATA     = 9'b010000000;
  localparam state_t S_RDATA_ACK = 9'b100000000;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// I2C pin bundle between a controller (master) and this target (slave).
// sda_in is the resolved wired-AND bus level.
interface i2c_target_regfile_if;
  logic i2c_scl;
  logic i2c_sda_in;
  logic i2c_sda_oe;

  modport master (
    output i2c_scl,
    output i2c_sda_in,
    input  i2c_sda_oe
  );

  modport slave (
    input  i2c_scl,
    input  i2c_sda_in,
    output i2c_sda_oe
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA 2-flop synchronizers with edge, START and STOP detection.
// Events are combinational from the synchronized and delayed levels.
module i2c_bus_sync (
  input  logic clk,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_q;
  logic [1:0] sda_q;
  logic scl_d;
  logic sda_d;

  always_ff @(posedge clk) begin
    scl_q <= {scl_q[0], scl};
    sda_q <= {sda_q[0], sda};
    scl_d <= scl_q[1];
    sda_d <= sda_q[1];
  end

  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_q[1] & ~scl_d;
  assign scl_fall  = ~scl_q[1] & scl_d;
  assign start_det = scl_q[1] & scl_d & sda_d & ~sda_q[1];
  assign stop_det  = scl_q[1] & scl_d & ~sda_d & sda_q[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C write target with byte register file and fabric read port.
// Define I2C_TARGET_READ_EN to also serve bus read transactions.
module i2c_target_regfile
  import i2c_target_regfile_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR = I2C_DEV_ADDR,
  parameter int REG_AW = 4
) (
  input  logic clk_ref,
  input  logic reset,
  i2c_target_regfile_if.slave bus,
  output logic busy,
  output logic wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int DEPTH = 2**REG_AW;

  state_t state, state_n;
  logic scl_rise, scl_fall;
  logic start_det, stop_det, sda_s;
  logic [3:0] cnt, cnt_n;
  logic [6:0] shreg, shreg_n;
  logic [7:0] tx, tx_n;
  logic [REG_AW-1:0] ptr, ptr_n;
  logic oe, oe_n, rw, rw_n;
  logic wr_en, rx, last_bit, dev_hit;
  logic [7:0] byte_in;
  logic [7:0] mem [DEPTH];

  i2c_bus_sync u_sync (
    .clk       (clk_ref),
    .scl       (bus.i2c_scl),
    .sda       (bus.i2c_sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign byte_in  = {shreg, sda_s};
  assign last_bit = scl_rise && cnt == 4'd7;
  assign rx = state[I_DEV] | state[I_REG]
            | state[I_WDATA];

`ifdef I2C_TARGET_READ_EN
  logic [7:0] cur;
  assign cur = mem[ptr];
  assign dev_hit = byte_in[7:1] == DEV_ADDR[7:1];
`else
  assign dev_hit = byte_in[7:1] == DEV_ADDR[7:1]
                && byte_in[0] == 1'b0;
`endif

  assign busy = ~state[I_IDLE];
  assign bus.i2c_sda_oe = oe;

  always_ff @(posedge clk_ref) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start_det) state_n = S_DEV;
    else if (stop_det) state_n = S_IDLE;
    else unique case (1'b1)
      state[I_IDLE]: ;
      state[I_DEV]:
        if (last_bit)
          state_n = dev_hit ? S_DEV_ACK : S_IDLE;
      state[I_DEV_ACK]:
        if (scl_fall && oe)
          state_n = rw ? S_RDATA : S_REG;
      state[I_REG]:
        if (last_bit) state_n = S_REG_ACK;
      state[I_REG_ACK]:
        if (scl_fall && oe) state_n = S_WDATA;
      state[I_WDATA]:
        if (last_bit) state_n = S_WDATA_ACK;
      state[I_WDATA_ACK]:
        if (scl_fall && oe) state_n = S_WDATA;
`ifdef I2C_TARGET_READ_EN
      state[I_RDATA]:
        if (scl_fall && cnt == 4'd8)
          state_n = S_RDATA_ACK;
      state[I_RDATA_ACK]: begin
        if (scl_rise && sda_s == I2C_NACK)
          state_n = S_IDLE;
        if (scl_fall && cnt != 4'd0)
          state_n = S_RDATA;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    cnt_n   = cnt;
    shreg_n = shreg;
    tx_n    = tx;
    ptr_n   = ptr;
    oe_n    = oe;
    rw_n    = rw;
    wr_en   = 1'b0;
    if (start_det || stop_det) begin
      cnt_n = '0;
      oe_n  = 1'b0;
    end else begin
      if (rx && scl_rise) begin
        shreg_n = byte_in[6:0];
        cnt_n = last_bit ? 4'd0 : cnt + 4'd1;
      end
      unique case (1'b1)
        state[I_DEV]:
          if (last_bit) rw_n = byte_in[0];
        state[I_REG]:
          if (last_bit) ptr_n = byte_in[REG_AW-1:0];
        state[I_WDATA]:
          if (last_bit) begin
            wr_en = 1'b1;
            ptr_n = ptr + REG_AW'(1);
          end
        state[I_DEV_ACK], state[I_REG_ACK],
        state[I_WDATA_ACK]:
          // first fall pulls SDA low, second fall releases it
          if (scl_fall) begin
            oe_n  = ~oe;
            cnt_n = '0;
`ifdef I2C_TARGET_READ_EN
            if (oe && rw && state[I_DEV_ACK]) begin
              tx_n  = cur;
              oe_n  = ~cur[7];
              cnt_n = 4'd1;
            end
`endif
          end
`ifdef I2C_TARGET_READ_EN
        state[I_RDATA]:
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              oe_n  = 1'b0;
              cnt_n = '0;
            end else begin
              oe_n  = ~tx[6];
              tx_n  = {tx[6:0], 1'b0};
              cnt_n = cnt + 4'd1;
            end
          end
        state[I_RDATA_ACK]: begin
          if (scl_rise && sda_s == I2C_ACK) begin
            ptr_n = ptr + REG_AW'(1);
            cnt_n = 4'd1;
          end
          if (scl_fall && cnt != 4'd0) begin
            tx_n = cur;
            oe_n = ~cur[7];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      cnt      <= '0;
      shreg    <= '0;
      tx       <= '0;
      ptr      <= '0;
      oe       <= 1'b0;
      rw       <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_data  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      ptr      <= ptr_n;
      oe       <= oe_n;
      rw       <= rw_n;
      wr_valid <= wr_en;
      rd_data  <= mem[rd_addr];
      if (wr_en) begin
        wr_addr  <= ptr;
        wr_data  <= byte_in;
        mem[ptr] <= byte_in;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench: bit-banged I2C controller against a register-file model.
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam int Q = 6;

  logic clk = 1'b0;
  logic reset;
  logic scl, sda;
  logic busy, wr_valid;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  i2c_target_regfile_if bus ();
  assign bus.i2c_scl = scl;
  assign bus.i2c_sda_in = sda & ~bus.i2c_sda_oe;

  i2c_target_regfile dut (
    .clk_ref  (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] m_mem [16];
  int m_ptr;
  logic [7:0] txq [$];
  logic [11:0] exp_wr [$];
  logic [11:0] obs_wr [$];

  always @(negedge clk)
    if (wr_valid) obs_wr.push_back({wr_addr, wr_data});

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_c();
    cyc(Q); sda = 1'b1;
    cyc(Q); scl = 1'b1;
    cyc(Q); sda = 1'b0;
    cyc(Q); scl = 1'b0;
  endtask

  task automatic stop_c();
    cyc(Q); sda = 1'b0;
    cyc(Q); scl = 1'b1;
    cyc(Q); sda = 1'b1;
    cyc(2*Q);
  endtask

  task automatic bit_out(input logic b);
    cyc(Q); sda = b;
    cyc(Q); scl = 1'b1;
    cyc(2*Q); scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    cyc(Q); sda = 1'b1;
    cyc(Q); scl = 1'b1;
    cyc(Q); b = bus.i2c_sda_in;
    cyc(Q); scl = 1'b0;
  endtask

  task automatic byte_out(input logic [7:0] d,
                          output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(b);
    ack = (b == 1'b0);
  endtask

  task automatic byte_in(input logic ack,
                         output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(~ack);
  endtask

  task automatic check_wr();
    check("wr_cnt", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size()
         && i < obs_wr.size(); i++)
      check("wr_ent", obs_wr[i], exp_wr[i]);
    obs_wr.delete();
    exp_wr.delete();
  endtask

  task automatic rd_chk(input string tag, input int idx);
    rd_addr = 4'(idx);
    cyc(1);
    check(tag, rd_data, m_mem[idx]);
  endtask

  task automatic wr_txn(input logic [7:0] dev,
                        input logic [7:0] rg,
                        input int n);
    logic ack, hit;
    hit = dev[7:1] == 7'h39 && dev[0] == 1'b0;
    start_c();
    byte_out(dev, ack);
    check("dev_ack", ack, hit);
    if (hit) begin
      byte_out(rg, ack);
      check("reg_ack", ack, 1);
      m_ptr = rg % 16;
      for (int i = 0; i < n; i++) begin
        byte_out(txq[i], ack);
        check("dat_ack", ack, 1);
        m_mem[m_ptr] = txq[i];
        exp_wr.push_back({4'(m_ptr), txq[i]});
        m_ptr = (m_ptr + 1) % 16;
      end
    end else begin
      cyc(2);
      check("nack_busy", busy, 0);
    end
    stop_c();
    cyc(4);
    check_wr();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: no finish, expected end");
    $fatal(1, "timeout");
  end

  initial begin
    logic ack;
    logic [7:0] d;
    reset = 1'b1; scl = 1'b1; sda = 1'b1;
    rd_addr = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_ptr = 0;
    cyc(4);
    reset = 1'b0;
    cyc(2);
    check("rst_oe", bus.i2c_sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wv", wr_valid, 0);
    check("rst_wa", wr_addr, 0);
    check("rst_wd", wr_data, 0);
    check("rst_rd", rd_data, 0);

    txq = '{8'h33};
    wr_txn(8'h72, 8'hA5, 1);
    rd_chk("t1_reg5", 5);

    wr_txn(8'h70, 8'h00, 0);
    txq = '{8'($urandom)};
    wr_txn(8'h72, 8'h06, 1);

    txq = '{8'h11, 8'h22};
    wr_txn(8'h72, 8'h0F, 2);
    rd_chk("wrap15", 15);
    rd_chk("wrap0", 0);

`ifdef I2C_TARGET_READ_EN
    start_c();
    byte_out(8'h72, ack); check("rd_w_dev", ack, 1);
    byte_out(8'h05, ack); check("rd_w_reg", ack, 1);
    m_ptr = 5;
    start_c();
    byte_out(8'h73, ack); check("rd_dev", ack, 1);
    byte_in(1'b1, d);
    check("rd_b0", d, m_mem[m_ptr]);
    m_ptr = (m_ptr + 1) % 16;
    byte_in(1'b0, d);
    check("rd_b1", d, m_mem[m_ptr]);
    cyc(4);
    check("rd_rel", bus.i2c_sda_oe, 0);
    check("rd_busy", busy, 0);
    stop_c();
`else
    wr_txn(8'h73, 8'h05, 0);
`endif

    // reset in the middle of a data byte
    start_c();
    byte_out(8'h72, ack); check("mr_dev", ack, 1);
    byte_out(8'h03, ack); check("mr_reg", ack, 1);
    for (int i = 0; i < 4; i++) bit_out(1'($urandom));
    check("mr_busy_pre", busy, 1);
    reset = 1'b1;
    cyc(1);
    check("mr_oe", bus.i2c_sda_oe, 0);
    check("mr_busy", busy, 0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_ptr = 0;
    stop_c();
    cyc(4);
    check_wr();
    for (int i = 0; i < 16; i++) rd_chk("mr_clr", i);
    txq = '{8'($urandom)};
    wr_txn(8'h72, 8'h03, 1);
    rd_chk("mr_after", 3);

    txq = '{8'($urandom_range(1, 255))};
    wr_txn(8'h72, 8'h09, 1);
    wr_txn(8'h72, 8'h09, 0);
`ifdef I2C_TARGET_READ_EN
    start_c();
    byte_out(8'h73, ack); check("ptr_dev", ack, 1);
    byte_in(1'b0, d);
    check("ptr_keep", d, m_mem[m_ptr]);
    stop_c();
`else
    rd_chk("ptr_keep", 9);
`endif

    for (int t = 0; t < 14; t++) begin
      logic [7:0] dv;
      int n;
      case ($urandom_range(0, 5))
        0: dv = 8'h70;
        1: dv = 8'hE4;
        default: dv = 8'h72;
      endcase
      n = $urandom_range(0, 3);
      txq.delete();
      for (int i = 0; i < n; i++)
        txq.push_back(8'($urandom));
      wr_txn(dv, 8'($urandom), n);
    end
    for (int i = 0; i < 16; i++) rd_chk("rnd_rd", i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
